controlador_display: RTL
========================

# controlador_display

Time-multiplexed scan controller for the vending machine's multi-digit seven-segment display. It holds a frame of 4-bit display codes, selects one digit at a time, and presents that digit's code to the shared segment decoder while driving the matching common anode. It adds anti-ghosting guard gaps, leading-zero blanking, per-digit blinking and tear-free frame updates.

## Interface
- N_DIGITS, 4: number of digits scanned; digit 0 is rightmost.
- SCAN_DIV, 1000: clock cycles per digit slot; must be ≥ GUARD+2.
- GUARD, 4: cycles at the start of each slot with all anodes off.
- BLINK_SLOTS, 128: complete frames per blink half-period.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe; captures data and lz_blank into the pending register.
- data  in  4*N_DIGITS  digit i code at [4i+3:4i]; decoder code map: 0–9 digits, A=E, B=n, C=P, D=dp, E/F blank.
- lz_blank  in  1  leading-zero blanking enable, sampled with load.
- blink  in  N_DIGITS  per-digit blink enable, sampled live.
- code  out  4  code to the segment decoder.
- anodo  out  N_DIGITS  digit enables, active-low, at most one low.
- frame_start  out  1  one-cycle pulse in the first cycle of each frame.

## Operation
- Registers:
  - cnt: 0..SCAN_DIV-1.
  - idx: 0..N_DIGITS-1.
  - pending plus pend_valid.
  - shadow (data and lz flag).
  - frm: 0..BLINK_SLOTS-1.
  - phase.
- All outputs are derived from registers only; there is no combinational path from inputs to outputs.
- Slot FSM:
  - GUARD while cnt < GUARD: anodo all ones.
  - SHOW while cnt ≥ GUARD: anodo[idx]=0, all other bits 1.
  - cnt increments each cycle. At SCAN_DIV-1 it wraps to 0 and idx advances; idx wraps N_DIGITS-1 → 0.
- Frame boundary is the edge where idx wraps to 0. On that edge:
  - If pend_valid: shadow ← pending, pend_valid ← 0.
  - frame_start is set for the next cycle.
  - frm increments. When frm wraps to 0, phase toggles.
- load: pending ← {data, lz_blank}, pend_valid ← 1. A later load overwrites pending (last wins).
- load on the frame-boundary edge: shadow takes the old pending value. The new data stays pending and is applied at the next boundary.
- Effective code for idx, in priority order:
  1. blink[idx]=1 and phase=1 → 4'hF.
  2. shadow lz=1, idx≠0, and shadow digits idx..N_DIGITS-1 are all 4'h0 → 4'hF.
  3. Otherwise → shadow digit idx.
- Digit 0 is never zero-blanked.
- code shows the effective code for the current idx during both GUARD and SHOW cycles.

## Timing
- Reset values (applied immediately on rst_n low, mid-operation included):
  - cnt=0, idx=0, frm=0, phase=0.
  - shadow all 4'hF, lz=0; pending cleared, pend_valid=0.
  - anodo all ones, code=4'hF, frame_start=0.
- After reset release, cycle 0 is GUARD of slot 0. frame_start stays 0 for this first frame.
- Slot length is SCAN_DIV cycles; anodo is low for exactly SCAN_DIV-GUARD consecutive cycles per slot.
- Frame length is N_DIGITS*SCAN_DIV cycles. frame_start is high in cycle (idx=0, cnt=0) of every frame except the first after reset.
- Load-to-display latency: visible from the first cycle of the next frame after the load edge, or the frame after that if the load coincides with the boundary edge.
- Blink half-period is BLINK_SLOTS frames. blink changes take effect on the next slot's code.
- Reset mid-operation discards pending data; the display returns to blank.

## Test plan
Use N_DIGITS=4, SCAN_DIV=16, GUARD=2, BLINK_SLOTS=2.
- Reset, then release → anodo=4'b1111, code=4'hF, frame_start=0. After release: 2 cycles anodo=1111, then 14 cycles anodo=1110; next slot 2 cycles 1111, then 14 cycles 1101.
- load data=16'h1234 at cnt=5 of slot 1 → current frame stays blank. Next frame: frame_start pulses; slots 0..3 show code 4,3,2,1 with anodo 1110,1101,1011,0111.
- load 16'h0070 with lz_blank=1 → slots 3,2,1,0 show F,F,7,0. load 16'h0000 → F,F,F,0. load 16'h0070 with lz_blank=0 → 0,0,7,0.
- Shadow 16'h5678, blink=4'b0100 → slot 2 shows 6 for 2 frames, then F for 2 frames, repeating; slots 0,1,3 are unaffected.
- load 16'hAAAA then 16'hBCD9 before the boundary → next frame shows 9,D,C,B (last wins). A load on the boundary edge is applied one frame later.
- Assert rst_n low during SHOW of slot 2 → anodo=1111 and code=F before the next clk edge; pending load is lost; display stays blank after release.

Source files
------------

// File: rtl/controlador_display_if.sv
// Bundle of signals between the vending-machine logic and the display scan
// controller. The scan controller sits on the slave side. Its frame data,
// blanking control and blink mask come in. The decoder code, the anode
// enables and the frame marker go out.
interface controlador_display_if #(
  parameter int N_DIGITS = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   data;
  logic                    lz_blank;
  logic [N_DIGITS-1:0]     blink;
  logic [3:0]              code;
  logic [N_DIGITS-1:0]     anodo;
  logic                    frame_start;

  modport master (
    output load, data, lz_blank, blink,
    input  code, anodo, frame_start
  );

  modport slave (
    input  load, data, lz_blank, blink,
    output code, anodo, frame_start
  );
endinterface

// File: rtl/controlador_display.sv
// Time-multiplexed seven-segment scan controller.
// The controller walks through the digits one slot at a time. At the start of
// each slot it leaves all anodes off for a short guard gap, which prevents
// ghosting. New frames are double-buffered: a load goes into a pending register
// and is copied into the shadow register only at a frame boundary. This keeps
// a frame from tearing. The code register is updated once per slot, so the
// outputs come only from flops.
module controlador_display #(
  parameter int N_DIGITS    = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int GUARD       = 4,
  parameter int BLINK_SLOTS = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  controlador_display_if.slave  dsp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam int DW = 4 * N_DIGITS;

  localparam logic [CW-1:0] LAST_CNT  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] LAST_FRM  = FW'(BLINK_SLOTS - 1);

  typedef enum logic {S_GUARD, S_SHOW} slot_state_t;

  slot_state_t         state, state_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [IW-1:0]       idx, idx_next;
  logic [FW-1:0]       frm;
  logic                phase, phase_next;
  logic [DW-1:0]       pend_data, shadow_data, shadow_next;
  logic                pend_lz, pend_valid, shadow_lz, lz_next;
  logic                slot_end, frame_end;
  logic [3:0]          code_q;
  logic                frame_start_q;
  logic [N_DIGITS-1:0] anodo_c;

  // Priority: blink-off phase first, then leading-zero blanking, then the raw digit.
  function automatic logic [3:0] effective_code(
    input logic [IW-1:0]       sel,
    input logic [DW-1:0]       digits,
    input logic                lz,
    input logic                ph,
    input logic [N_DIGITS-1:0] blk
  );
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i >= int'(sel) && digits[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    if (blk[sel] && ph) return 4'hF;
    if (lz && sel != '0 && upper_zero) return 4'hF;
    return digits[4*int'(sel) +: 4];
  endfunction

  assign slot_end  = (cnt == LAST_CNT);
  assign frame_end = slot_end && (idx == LAST_IDX);

  // Next-state logic for the slot FSM. The anodes are decoded from the registered state.
  always_comb begin
    cnt_next   = cnt + 1'b1;
    idx_next   = idx;
    state_next = state;
    anodo_c    = '1;
    if (slot_end) begin
      cnt_next = '0;
      idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
    state_next = (cnt_next < GUARD_CNT) ? S_GUARD : S_SHOW;
    if (state == S_SHOW) anodo_c[idx] = 1'b0;
  end

  // Values the shadow and blink phase will take after this edge; the code register looks ahead with them.
  always_comb begin
    shadow_next = shadow_data;
    lz_next     = shadow_lz;
    phase_next  = phase;
    if (frame_end) begin
      if (pend_valid) begin
        shadow_next = pend_data;
        lz_next     = pend_lz;
      end
      if (frm == LAST_FRM) phase_next = ~phase;
    end
  end

  // Slot FSM state, cycle counter within the slot and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_GUARD;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // Frame counter, blink phase and the one-cycle frame marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm           <= '0;
      phase         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_end;
      phase         <= phase_next;
      if (frame_end) frm <= (frm == LAST_FRM) ? '0 : frm + 1'b1;
    end
  end

  // Double buffer: a load on the boundary edge still lets the old pending value reach the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data   <= '0;
      pend_lz     <= 1'b0;
      pend_valid  <= 1'b0;
      shadow_data <= '1;
      shadow_lz   <= 1'b0;
    end else begin
      shadow_data <= shadow_next;
      shadow_lz   <= lz_next;
      if (frame_end && pend_valid) pend_valid <= 1'b0;
      if (dsp.load) begin
        pend_data  <= dsp.data;
        pend_lz    <= dsp.lz_blank;
        pend_valid <= 1'b1;
      end
    end
  end

  // The decoder code is latched once per slot for the digit that is about to be scanned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= 4'hF;
    end else if (slot_end) begin
      code_q <= effective_code(idx_next, shadow_next, lz_next, phase_next, dsp.blink);
    end
  end

  assign dsp.code        = code_q;
  assign dsp.anodo       = anodo_c;
  assign dsp.frame_start = frame_start_q;

endmodule
